// File: rtl/rst_sequencer_if.sv
// Bundle of the reset-sequencer control/status signals shared between the
// sequencer (slave) and whoever requests software resets (master).
interface rst_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    // soft_rst_req is sampled on every rising edge; soft_rst_ack is high for
    // exactly the cycles following each edge at which a request was accepted.
    // There is no back-pressure: a request is always accepted unless rst is high.
    logic                  soft_rst_req;
    logic                  soft_rst_ack;
    logic [NUM_STAGES-1:0] rst_out;
    logic                  busy;
    logic                  seq_done;

    modport master (
        output soft_rst_req,
        input  soft_rst_ack,
        input  rst_out,
        input  busy,
        input  seq_done
    );

    modport slave (
        input  soft_rst_req,
        output soft_rst_ack,
        output rst_out,
        output busy,
        output seq_done
    );
endinterface

// File: rtl/rst_sequencer.sv
// Staged reset controller: holds all domain resets for a minimum pulse, then
// releases them one at a time, lowest bit first, with fixed spacing.
module rst_sequencer #(
    parameter int NUM_STAGES = 3,
    parameter int PULSE_MIN  = 8,
    parameter int STAGE_DLY  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    rst_sequencer_if.slave        rs_if,
    output logic [1:0]            dbg_state_o
);
    localparam int CNT_MAX = (PULSE_MIN > STAGE_DLY) ? PULSE_MIN : STAGE_DLY;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_STAGES + 1);

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_MIN - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DLY - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ack_q     <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        ack_d     = 1'b0;

        if (rs_if.soft_rst_req) begin
            // The request edge becomes edge 0 of a fresh sequence.
            state_d   = S_HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            ack_d     = 1'b1;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (cnt_q == PULSE_LAST) begin
                        rst_out_d[0] = 1'b0;
                        cnt_d        = '0;
                        idx_d        = IW'(1);
                        state_d      = (NUM_STAGES == 1) ? S_DONE : S_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == STAGE_LAST) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (idx_q == IW'(i)) rst_out_d[i] = 1'b0;
                        end
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end

        // Status flops follow the next reset vector so they change on the same edge.
        busy_d = |rst_out_d;
        done_d = ~(|rst_out_d);
    end

    assign rs_if.rst_out      = rst_out_q;
    assign rs_if.soft_rst_ack = ack_q;
    assign rs_if.busy         = busy_q;
    assign rs_if.seq_done     = done_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default configuration plus the
// single-stage and eight-stage/back-to-back parameter corners.
module tb_rst_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rst_sequencer_if #(.NUM_STAGES(3)) m_if ();
  rst_sequencer_if #(.NUM_STAGES(1)) c1_if ();
  rst_sequencer_if #(.NUM_STAGES(8)) c8_if ();

  logic [1:0] m_state, c1_state, c8_state;

  rst_sequencer #(.NUM_STAGES(3), .PULSE_MIN(8), .STAGE_DLY(16)) dut (
    .clk(clk), .rst(rst), .rs_if(m_if.slave), .dbg_state_o(m_state));
  rst_sequencer #(.NUM_STAGES(1), .PULSE_MIN(1), .STAGE_DLY(16)) dut_c1 (
    .clk(clk), .rst(rst), .rs_if(c1_if.slave), .dbg_state_o(c1_state));
  rst_sequencer #(.NUM_STAGES(8), .PULSE_MIN(8), .STAGE_DLY(1)) dut_c8 (
    .clk(clk), .rst(rst), .rs_if(c8_if.slave), .dbg_state_o(c8_state));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_v;
  logic [2:0] exp3;

  // Expected reset vector after edge e of a sequence.
  function automatic logic [7:0] exp_rst(input int e, input int ns, input int pm, input int sd);
    int r;
    logic [7:0] all_m, rel_m;
    if (e < pm) r = 0;
    else r = 1 + (e - pm) / sd;
    if (r > ns) r = ns;
    all_m = 8'((1 << ns) - 1);
    rel_m = 8'((1 << r) - 1);
    return all_m & ~rel_m;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    m_if.soft_rst_req = 1'b0;
    c1_if.soft_rst_req = 1'b0;
    c8_if.soft_rst_req = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (m_if.rst_out !== 3'b111) begin errors++; $display("FAIL reset_rst_out got=%b exp=111", m_if.rst_out); end
    checks++; if (m_if.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", m_if.busy); end
    checks++; if (m_if.seq_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", m_if.seq_done); end
    checks++; if (m_if.soft_rst_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", m_if.soft_rst_ack); end
    checks++; if (m_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", m_state); end
    checks++; if (c1_if.rst_out !== 1'b1) begin errors++; $display("FAIL reset_c1 got=%b exp=1", c1_if.rst_out); end
    checks++; if (c8_if.rst_out !== 8'hFF) begin errors++; $display("FAIL reset_c8 got=%h exp=ff", c8_if.rst_out); end
  endtask

  task automatic test_power_on();
    rst = 1'b0;
    for (int e = 1; e <= 42; e++) begin
      @(negedge clk);
      exp_v = exp_rst(e, 3, 8, 16);
      exp3 = exp_v[2:0];
      checks++; if (m_if.rst_out !== exp3) begin errors++; $display("FAIL pon_rst_out e=%0d got=%b exp=%b", e, m_if.rst_out, exp3); end
      checks++; if (m_if.seq_done !== (exp3 == 3'b000)) begin errors++; $display("FAIL pon_done e=%0d got=%b", e, m_if.seq_done); end
      checks++; if (m_if.busy !== (exp3 != 3'b000)) begin errors++; $display("FAIL pon_busy e=%0d got=%b", e, m_if.busy); end
      checks++; if (m_if.soft_rst_ack !== 1'b0) begin errors++; $display("FAIL pon_ack e=%0d got=%b exp=0", e, m_if.soft_rst_ack); end
    end
    checks++; if (m_state !== 2'd2) begin errors++; $display("FAIL pon_state got=%0d exp=2", m_state); end
  endtask

  task automatic test_async_assert();
    #2 rst = 1'b1;
    #1;
    checks++; if (m_if.rst_out !== 3'b111) begin errors++; $display("FAIL async_rst_out got=%b exp=111", m_if.rst_out); end
    checks++; if (m_if.seq_done !== 1'b0) begin errors++; $display("FAIL async_done got=%b exp=0", m_if.seq_done); end
    checks++; if (m_if.busy !== 1'b1) begin errors++; $display("FAIL async_busy got=%b exp=1", m_if.busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 42; e++) begin
      @(negedge clk);
      exp_v = exp_rst(e, 3, 8, 16);
      exp3 = exp_v[2:0];
      checks++; if (m_if.rst_out !== exp3) begin errors++; $display("FAIL async_seq e=%0d got=%b exp=%b", e, m_if.rst_out, exp3); end
      checks++; if (m_if.seq_done !== (exp3 == 3'b000)) begin errors++; $display("FAIL async_seq_done e=%0d got=%b", e, m_if.seq_done); end
    end
  endtask

  task automatic test_soft_done();
    m_if.soft_rst_req = 1'b1;
    @(negedge clk);
    m_if.soft_rst_req = 1'b0;
    checks++; if (m_if.soft_rst_ack !== 1'b1) begin errors++; $display("FAIL soft_done_ack got=%b exp=1", m_if.soft_rst_ack); end
    checks++; if (m_if.rst_out !== 3'b111) begin errors++; $display("FAIL soft_done_rst_out got=%b exp=111", m_if.rst_out); end
    checks++; if (m_if.seq_done !== 1'b0) begin errors++; $display("FAIL soft_done_done got=%b exp=0", m_if.seq_done); end
    for (int e = 1; e <= 42; e++) begin
      @(negedge clk);
      exp_v = exp_rst(e, 3, 8, 16);
      exp3 = exp_v[2:0];
      checks++; if (m_if.soft_rst_ack !== 1'b0) begin errors++; $display("FAIL soft_done_ack_pulse e=%0d got=%b exp=0", e, m_if.soft_rst_ack); end
      checks++; if (m_if.rst_out !== exp3) begin errors++; $display("FAIL soft_done_seq e=%0d got=%b exp=%b", e, m_if.rst_out, exp3); end
      checks++; if (m_if.seq_done !== (exp3 == 3'b000)) begin errors++; $display("FAIL soft_done_seq_done e=%0d got=%b", e, m_if.seq_done); end
    end
  endtask

  task automatic test_soft_mid_release();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (29) @(negedge clk);
    checks++; if (m_if.rst_out !== 3'b100) begin errors++; $display("FAIL mid_pre got=%b exp=100", m_if.rst_out); end
    m_if.soft_rst_req = 1'b1;
    @(negedge clk);
    m_if.soft_rst_req = 1'b0;
    checks++; if (m_if.rst_out !== 3'b111) begin errors++; $display("FAIL mid_reassert got=%b exp=111", m_if.rst_out); end
    checks++; if (m_if.soft_rst_ack !== 1'b1) begin errors++; $display("FAIL mid_ack got=%b exp=1", m_if.soft_rst_ack); end
    for (int e = 1; e <= 42; e++) begin
      @(negedge clk);
      exp_v = exp_rst(e, 3, 8, 16);
      exp3 = exp_v[2:0];
      checks++; if (m_if.rst_out !== exp3) begin errors++; $display("FAIL mid_seq e=%0d got=%b exp=%b", e, m_if.rst_out, exp3); end
      checks++; if (m_if.seq_done !== (exp3 == 3'b000)) begin errors++; $display("FAIL mid_seq_done e=%0d got=%b", e, m_if.seq_done); end
    end
  endtask

  task automatic test_held_and_priority();
    m_if.soft_rst_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (m_if.rst_out !== 3'b111) begin errors++; $display("FAIL held_rst_out i=%0d got=%b exp=111", i, m_if.rst_out); end
      checks++; if (m_if.soft_rst_ack !== 1'b1) begin errors++; $display("FAIL held_ack i=%0d got=%b exp=1", i, m_if.soft_rst_ack); end
    end
    m_if.soft_rst_req = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      exp_v = exp_rst(e, 3, 8, 16);
      exp3 = exp_v[2:0];
      checks++; if (m_if.rst_out !== exp3) begin errors++; $display("FAIL held_release e=%0d got=%b exp=%b", e, m_if.rst_out, exp3); end
    end
    rst = 1'b1;
    m_if.soft_rst_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (m_if.soft_rst_ack !== 1'b0) begin errors++; $display("FAIL prio_ack i=%0d got=%b exp=0", i, m_if.soft_rst_ack); end
      checks++; if (m_if.rst_out !== 3'b111) begin errors++; $display("FAIL prio_rst_out i=%0d got=%b exp=111", i, m_if.rst_out); end
    end
    rst = 1'b0;
    m_if.soft_rst_req = 1'b0;
    @(negedge clk);
    checks++; if (m_if.soft_rst_ack !== 1'b0) begin errors++; $display("FAIL prio_after_ack got=%b exp=0", m_if.soft_rst_ack); end
  endtask

  task automatic test_corners();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (c1_if.rst_out !== 1'b1) begin errors++; $display("FAIL c1_e0 got=%b exp=1", c1_if.rst_out); end
    checks++; if (c1_if.seq_done !== 1'b0) begin errors++; $display("FAIL c1_e0_done got=%b exp=0", c1_if.seq_done); end
    for (int e = 1; e <= 18; e++) begin
      @(negedge clk);
      exp_v = exp_rst(e, 1, 1, 16);
      checks++; if (c1_if.rst_out !== exp_v[0]) begin errors++; $display("FAIL c1_seq e=%0d got=%b exp=%b", e, c1_if.rst_out, exp_v[0]); end
      checks++; if (c1_if.seq_done !== ~exp_v[0]) begin errors++; $display("FAIL c1_done e=%0d got=%b", e, c1_if.seq_done); end
      exp_v = exp_rst(e, 8, 8, 1);
      checks++; if (c8_if.rst_out !== exp_v) begin errors++; $display("FAIL c8_seq e=%0d got=%h exp=%h", e, c8_if.rst_out, exp_v); end
      checks++; if (c8_if.seq_done !== (exp_v == 8'h00)) begin errors++; $display("FAIL c8_done e=%0d got=%b", e, c8_if.seq_done); end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_async_assert();
    test_soft_done();
    test_soft_mid_release();
    test_held_and_priority();
    test_corners();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Staged reset controller for the UART processor. It takes the board-level asynchronous reset plus a synchronous software reset request, and holds every downstream reset asserted for a minimum pulse. It then releases the domains one at a time, in fixed order (for example bus/processor, then UART RX, then UART TX), with a programmable spacing between releases. Assertion is immediate; every release is synchronous to `clk`. It sits directly above the per-block reset consumers and replaces ad-hoc reset fan-out.

## Interface
- `NUM_STAGES`, default 3: number of reset domains sequenced. Legal range 1–8.
- `PULSE_MIN`, default 8: clock edges all outputs stay asserted before stage 0 is released. Must be ≥1.
- `STAGE_DLY`, default 16: clock edges between consecutive stage releases. Must be ≥1.
- `clk`, input, 1: system clock. All state changes except reset occur on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `soft_rst_req`, input, 1: synchronous software reset request, active-high, sampled each rising edge.
- `soft_rst_ack`, output, 1: one-cycle pulse confirming that a request was accepted.
- `rst_out`, output, `NUM_STAGES`: per-domain resets, active-high. Bit 0 is released first.
- `busy`, output, 1: high while any `rst_out` bit is asserted.
- `seq_done`, output, 1: high once all stages are released. Always equals `~busy`.

## Operation
- **States:** HOLD and RELEASE, plus the DONE condition.
  - HOLD: all outputs asserted; the pulse counter is running.
  - RELEASE: stages are released one per `STAGE_DLY` edges.
  - DONE: all outputs released; the controller is idle.
- **Async reset (`rst` high):** takes effect immediately, with no clock required.
  - State = HOLD, counter = 0, stage index = 0.
  - `rst_out` = all ones, `busy` = 1, `seq_done` = 0, `soft_rst_ack` = 0.
  - Outputs hold these values while `rst` stays high.
- **HOLD:** the counter increments each edge. At the edge where the count reaches `PULSE_MIN`:
  - `rst_out[0]` is cleared.
  - The state moves to RELEASE with stage index = 1 and the counter reset.
  - If `NUM_STAGES` = 1, the state moves to DONE instead.
- **RELEASE:** the counter increments each edge. At every `STAGE_DLY`-th edge:
  - `rst_out[index]` is cleared, the index increments, and the counter resets.
  - Clearing the last bit moves the state to DONE and sets `seq_done` on that same edge.
- **DONE:** holds until a soft request or `rst`.
- **Release ordering:** `rst_out` bits are released in order only. Once bit k is clear, all lower bits are also clear.
- **Soft request:** `soft_rst_req` is sampled high at edge E, in any state.
  - At edge E, all `rst_out` bits are set to 1, the state goes to HOLD, the counter resets to 0, and `soft_rst_ack` is set for that one cycle.
  - The sequence then restarts exactly as after `rst`, with edge E treated as edge 0.
  - A request arriving mid-RELEASE re-asserts the stages already released. No partial sequence continues.
  - A request held high keeps restarting HOLD, so outputs stay fully asserted. `soft_rst_ack` stays high for every edge the request is sampled high.
- **Priority:** `rst` has priority over `soft_rst_req`. A request sampled on an edge during which `rst` is high is ignored and not acknowledged.
- **Counter width:** counter width = clog2(max(`PULSE_MIN`, `STAGE_DLY`) + 1). The counter never wraps, because it is cleared on every stage event.

## Timing
- **Edge numbering:** edge 1 is the first rising edge with `rst` low (or the first edge after soft-request edge E).
- **Release edges:**
  - `rst_out[0]` falls after edge `PULSE_MIN`.
  - `rst_out[k]` falls after edge `PULSE_MIN` + k·`STAGE_DLY`.
- **Completion:** `seq_done` rises and `busy` falls on the same edge as the last stage release, i.e. `PULSE_MIN` + (`NUM_STAGES`−1)·`STAGE_DLY`.
  - With defaults, releases occur at edges 8, 24 and 40; `seq_done` rises at edge 40.
- **Latency:**
  - Assertion latency from `rst`: combinational through the flop async preset, zero clock cycles.
  - Assertion latency from `soft_rst_req`: one edge, i.e. outputs assert at the sampling edge.
- **Glitch-free outputs:** all outputs are driven directly from flops.

## Test plan
- **Power-on:** hold `rst` = 1 for 5 cycles, then release, with defaults.
  - Expect `rst_out` = 3'b111 before release, 3'b110 after edge 8, 3'b100 after edge 24, and 3'b000 after edge 40.
  - Expect `seq_done` rising at edge 40.
- **Async assertion:** in DONE, raise `rst` mid-cycle.
  - Expect `rst_out` = 3'b111 and `seq_done` = 0 before the next clock edge.
  - After release, expect the full 8/24/40 sequence again.
- **Soft reset in DONE:** pulse `soft_rst_req` for 1 cycle at edge E.
  - Expect `soft_rst_ack` = 1 for exactly one cycle and `rst_out` = 3'b111 at E.
  - Expect releases at E+8, E+24 and E+40.
- **Soft reset mid-RELEASE:** apply the request at edge 30 after power-on, when `rst_out` = 3'b100.
  - Expect 3'b111 at edge 30 and a restarted sequence (E+8, E+24, E+40). Bit 0 must not stay clear.
- **Held request and priority:**
  - Hold `soft_rst_req` high for 20 cycles: `rst_out` stays 3'b111 throughout, and `rst_out[0]` releases 8 edges after the last sampled-high edge.
  - Assert the request while `rst` = 1: expect no ack.
- **Parameter corners:** run `NUM_STAGES` = 1 with `PULSE_MIN` = 1.
  - `rst_out[0]` and `seq_done` must both change after edge 1.
  - Rerun `STAGE_DLY` = 1 with `NUM_STAGES` = 8: expect releases on consecutive edges 8 through 15.
